// File: rtl/ac_i2s_serializer_if.sv
// Generator/codec-side signal bundle for the I2S serializer.
// master = generator/codec side, slave = serializer side.
interface ac_i2s_serializer_if #(
  parameter int DATA_WDT = 24
);
  logic                cmdModEn;
  logic [DATA_WDT-1:0] genDataL;
  logic [DATA_WDT-1:0] genDataR;
  logic                tick;
  logic [DATA_WDT-1:0] adcDataL;
  logic [DATA_WDT-1:0] adcDataR;
  logic                bclk;
  logic                lrclk;
  logic                dacdat;
  logic                adcdat;

  modport master (
    output cmdModEn, genDataL, genDataR, adcdat,
    input  tick, adcDataL, adcDataR, bclk, lrclk, dacdat
  );

  modport slave (
    input  cmdModEn, genDataL, genDataR, adcdat,
    output tick, adcDataL, adcDataR, bclk, lrclk, dacdat
  );
endinterface

// File: rtl/ac_i2s_serializer.sv
// I2S master: derives bclk/lrclk from clk, shifts DAC words out MSB-first,
// captures ADC words and pulses tick once per 64-bit frame.
module ac_i2s_serializer #(
  parameter int DATA_WDT = 24,
  parameter int BCLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  ac_i2s_serializer_if.slave  i2s
);
  localparam int                DIV_W     = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [4:0]        SLOT_LAST = 5'(DATA_WDT);

  logic [DIV_W-1:0]    div_cnt_reg;
  logic [5:0]          bit_cnt_reg;
  logic                bclk_reg;
  logic                lrclk_reg;
  logic                dacdat_reg;
  logic                tick_reg;
  logic [DATA_WDT-1:0] adc_l_reg, adc_r_reg;
  logic [DATA_WDT-1:0] tx_l_reg, tx_r_reg;
  logic [DATA_WDT-1:0] rx_l_reg, rx_r_reg;

  logic       div_wrap, fall_ev, rise_ev;
  logic [5:0] bit_cnt_next;
  logic       next_in_word, cur_in_word;

  always_comb begin
    div_wrap     = (div_cnt_reg == DIV_LAST);
    fall_ev      = div_wrap & bclk_reg;
    rise_ev      = div_wrap & ~bclk_reg;
    bit_cnt_next = bit_cnt_reg + 6'd1;
    // Slot bit 0 and bits past the word carry zero padding / are ignored.
    next_in_word = (bit_cnt_next[4:0] != 5'd0) && (bit_cnt_next[4:0] <= SLOT_LAST);
    cur_in_word  = (bit_cnt_reg[4:0] != 5'd0) && (bit_cnt_reg[4:0] <= SLOT_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= 6'd63;
      bclk_reg    <= 1'b0;
      lrclk_reg   <= 1'b0;
      dacdat_reg  <= 1'b0;
      tick_reg    <= 1'b0;
      adc_l_reg   <= '0;
      adc_r_reg   <= '0;
      tx_l_reg    <= '0;
      tx_r_reg    <= '0;
      rx_l_reg    <= '0;
      rx_r_reg    <= '0;
    end else if (!i2s.cmdModEn) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= 6'd63;
      bclk_reg    <= 1'b0;
      lrclk_reg   <= 1'b0;
      dacdat_reg  <= 1'b0;
      tick_reg    <= 1'b0;
      adc_l_reg   <= '0;
      adc_r_reg   <= '0;
      tx_l_reg    <= '0;
      tx_r_reg    <= '0;
      rx_l_reg    <= '0;
      rx_r_reg    <= '0;
    end else begin
      tick_reg    <= 1'b0;
      div_cnt_reg <= div_wrap ? '0 : div_cnt_reg + DIV_W'(1);
      if (div_wrap) bclk_reg <= ~bclk_reg;

      if (fall_ev) begin
        bit_cnt_reg <= bit_cnt_next;
        lrclk_reg   <= bit_cnt_next[5];
        if (bit_cnt_next == 6'd0) begin
          tx_l_reg  <= i2s.genDataL;
          tx_r_reg  <= i2s.genDataR;
          adc_l_reg <= rx_l_reg;
          adc_r_reg <= rx_r_reg;
          tick_reg  <= 1'b1;
        end
        // Shifting out the MSB each slot bit is equivalent to picking bit DATA_WDT-s.
        if (next_in_word) begin
          if (bit_cnt_next[5]) begin
            dacdat_reg <= tx_r_reg[DATA_WDT-1];
            tx_r_reg   <= {tx_r_reg[DATA_WDT-2:0], 1'b0};
          end else begin
            dacdat_reg <= tx_l_reg[DATA_WDT-1];
            tx_l_reg   <= {tx_l_reg[DATA_WDT-2:0], 1'b0};
          end
        end else begin
          dacdat_reg <= 1'b0;
        end
      end

      if (rise_ev && cur_in_word) begin
        if (bit_cnt_reg[5]) rx_r_reg <= {rx_r_reg[DATA_WDT-2:0], i2s.adcdat};
        else                rx_l_reg <= {rx_l_reg[DATA_WDT-2:0], i2s.adcdat};
      end
    end
  end

  assign i2s.tick     = tick_reg;
  assign i2s.adcDataL = adc_l_reg;
  assign i2s.adcDataR = adc_r_reg;
  assign i2s.bclk     = bclk_reg;
  assign i2s.lrclk    = lrclk_reg;
  assign i2s.dacdat   = dacdat_reg;
endmodule
